// File: rtl/req_arbiter.sv
// Two-requester arbiter with last-served tie-breaking, bounded hold time and
// a wrapping grant counter. All outputs except out1 are registered.
module req_arbiter #(
  parameter int unsigned MAXHOLD = 4,
  parameter int unsigned CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in1,
  input  logic          in2,
  input  logic          done,
  output logic          out1,
  output logic          gnt1,
  output logic          gnt2,
  output logic          busy,
  output logic          tmo,
  output logic [CW-1:0] gcnt
);

  localparam int unsigned HW = $clog2(MAXHOLD) + 1;
  localparam logic [HW-1:0] HLIM = HW'(MAXHOLD - 1);

  typedef enum logic [1:0] {IDLE, G1, G2} state_t;

  state_t        state, state_nx;
  logic          last2, last2_nx;   // 1: requester 2 served last
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [CW-1:0] gcnt_nx;
  logic          tmo_nx;

  assign out1 = in1 | in2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last2 <= 1'b1;
      hcnt  <= '0;
      gcnt  <= '0;
      tmo   <= 1'b0;
      gnt1  <= 1'b0;
      gnt2  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      last2 <= last2_nx;
      hcnt  <= hcnt_nx;
      gcnt  <= gcnt_nx;
      tmo   <= tmo_nx;
      gnt1  <= (state_nx == G1);
      gnt2  <= (state_nx == G2);
      busy  <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    last2_nx = last2;
    hcnt_nx  = hcnt;
    gcnt_nx  = gcnt;
    tmo_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (in1 && (!in2 || last2)) begin
          state_nx = G1;
          last2_nx = 1'b0;
          hcnt_nx  = '0;
          gcnt_nx  = gcnt + CW'(1);
        end else if (in2) begin
          state_nx = G2;
          last2_nx = 1'b1;
          hcnt_nx  = '0;
          gcnt_nx  = gcnt + CW'(1);
        end
      end
      G1, G2: begin
        // done and withdrawal take priority over timeout, so tmo only on a pure timeout
        if (done || (state == G1 ? !in1 : !in2)) begin
          state_nx = IDLE;
        end else if (hcnt == HLIM) begin
          state_nx = IDLE;
          tmo_nx   = 1'b1;
        end else begin
          hcnt_nx = hcnt + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter MAXHOLD, default 4: maximum cycles a grant is held before forced release (legal range 2..255).
REQ-002 Parameter CW, default 8: width of the grant-count output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in1  input  1  request from requester 1, level, held until served or withdrawn.
REQ-006 in2  input  1  request from requester 2, same rules as in1.
REQ-007 done  input  1  one-cycle completion pulse from the currently granted requester.
REQ-008 out1  output  1  combinational in1 OR in2 ("any request").
REQ-009 gnt1  output  1  registered grant to requester 1.
REQ-010 gnt2  output  1  registered grant to requester 2.
REQ-011 busy  output  1  registered, equals gnt1 OR gnt2.
REQ-012 tmo  output  1  registered one-cycle pulse on forced release.
REQ-013 gcnt  output  CW  registered count of grants issued, wraps 2^CW-1 -> 0.

Function
REQ-014 FSM states IDLE, G1, G2; gnt1=1 only in G1, gnt2=1 only in G2; never both high.
REQ-015 Internal last-served flag: 1 = requester 1 served last, 2 = requester 2.
REQ-016 IDLE -> G1 if in1 and not in2, or both requesting and last=2; IDLE -> G2 if in2 and not in1, or both requesting and last=1.
REQ-017 Grant latency: gntX high on the first edge after inX sampled high in IDLE (1 cycle).
REQ-018 On entering G1/G2: last updated to that requester, gcnt incremented by 1, hold counter cleared to 0.
REQ-019 In GX, hold counter increments each cycle; counter width ceil(log2(MAXHOLD))+1, never wraps.
REQ-020 GX -> IDLE on: done=1 (normal), inX=0 (withdrawal), or hold counter = MAXHOLD-1 (timeout).
REQ-021 tmo pulses high for exactly the first IDLE cycle after a timeout release only.
REQ-022 done and timeout in same cycle: treated as normal release, tmo stays 0.
REQ-023 inX withdrawn and timeout in same cycle: treated as withdrawal, tmo stays 0.
REQ-024 Every release spends at least one cycle in IDLE (no back-to-back grant, no overlap).
REQ-025 done in IDLE ignored; done affects only the current grant.
REQ-026 Requests of the non-granted requester do not affect the current grant.
REQ-027 out1 is purely combinational, valid during and after reset.

Reset
REQ-028 rst_n=0 forces immediately, independent of clk: state IDLE, gnt1=0, gnt2=0, busy=0, tmo=0, gcnt=0, hold counter 0, last=2 (requester 1 wins first tie).
REQ-029 Reset asserted mid-grant drops the grant asynchronously; no tmo and no gcnt change results.
REQ-030 After rst_n deasserts, first state change occurs on the first subsequent rising edge.

Verification (MAXHOLD=4, CW=8)
REQ-031 Reset, in1=in2=1 at cycle 0 -> gnt1=1 at cycle 1, gcnt=1, out1=1; done at cycle 2 -> IDLE cycle 3, gnt2=1 cycle 4, gcnt=2.
REQ-032 in2=1 alone, done never asserted -> gnt2 high 4 cycles, then IDLE with tmo=1 for 1 cycle, gnt2 re-granted next cycle, gcnt=2.
REQ-033 Grant to in1, in1 dropped at hold count 3 simultaneous with timeout -> release, tmo=0.
REQ-034 done pulse in IDLE with no requests -> no output change, gcnt unchanged.
REQ-035 256 single grants via done -> gcnt wraps to 0, busy and gnt never overlap.
REQ-036 rst_n low mid-G1 between edges -> gnt1, busy fall without clock edge; gcnt=0; after release, tie resolves to gnt1.
